// File: rtl/dp_ram_sync.sv
// ---------------------------------------------------------------------------
// dp_ram_sync -- synchronous true dual-port RAM, one clock, two ports (A, B)
//
// Purpose:
//   Scratch/buffer memory shared by two independent ports. Each port does one
//   read or one write per rising edge. Read data is registered (one-cycle
//   latency) and holds its value until the next read on that port or reset.
//
// Ports:
//   clk        common clock, rising-edge active
//   rst_n      synchronous active-low reset: clears the read registers and
//              blocks writes; memory contents are never cleared
//   a_wr       port A: 1 = write, 0 = read
//   a_addr     port A word address
//   a_din      port A write data
//   a_dout     port A registered read data
//   b_wr       port B: 1 = write, 0 = read
//   b_addr     port B word address
//   b_din      port B write data
//   b_dout     port B registered read data
//   collision  (only with DPRAM_COLLISION_EN) registered flag, high for the
//              cycle after an edge where both ports hit the same address and
//              at least one of them writes
//
// Configuration macro:
//   DPRAM_COLLISION_EN  adds the collision output and its register.
//
// Ordering rules:
//   - a read on one port and a write on the other to the same address returns
//     the old contents (read-before-write);
//   - two writes to the same address: port A's data is stored.
// ---------------------------------------------------------------------------
module dp_ram_sync #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  a_wr,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_din,
    output logic [DATA_WIDTH-1:0] a_dout,
    input  logic                  b_wr,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_din,
    output logic [DATA_WIDTH-1:0] b_dout
`ifdef DPRAM_COLLISION_EN
    ,
    output logic                  collision
`endif
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    // Shared storage; deliberately not reset so it maps onto block RAM.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Port signals gathered into arrays so both read paths come from one
    // generate loop (index 0 = A, index 1 = B).
    logic [1:0]            port_wr;
    logic [ADDR_WIDTH-1:0] port_addr [2];

    assign port_wr      = {b_wr, a_wr};
    assign port_addr[0] = a_addr;
    assign port_addr[1] = b_addr;

    // B's write is suppressed when A writes the same word, giving A priority
    // without relying on assignment order inside the block.
    logic same_addr;
    logic b_write_ok;

    assign same_addr  = (a_addr == b_addr);
    assign b_write_ok = b_wr && !(a_wr && same_addr);

    // Write path. Writes are ignored while reset is asserted.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (b_write_ok) begin
                mem[b_addr] <= b_din;
            end
            if (a_wr) begin
                mem[a_addr] <= a_din;
            end
        end
    end

    // Read path per port. The read samples mem before this edge's writes
    // land, which yields read-before-write across ports. On a write cycle
    // the register holds (no write-through).
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
            logic [DATA_WIDTH-1:0] dout_reg;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    dout_reg <= '0;
                end else if (!port_wr[gi]) begin
                    dout_reg <= mem[port_addr[gi]];
                end
            end
        end
    endgenerate

    assign a_dout = g_rd[0].dout_reg;
    assign b_dout = g_rd[1].dout_reg;

`ifdef DPRAM_COLLISION_EN
    // Flag any same-address access involving a write; a pure read/read
    // overlap is harmless and not flagged.
    logic collision_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            collision_reg <= 1'b0;
        end else begin
            collision_reg <= same_addr && (a_wr || b_wr);
        end
    end

    assign collision = collision_reg;
`endif

endmodule

// File: tb/tb_dp_ram_sync.sv
// Testbench for dp_ram_sync: directed sequences plus randomized traffic,
// scored against a word-array reference model through an expectation queue.
module tb_dp_ram_sync;

    localparam int DW    = 8;
    localparam int AW    = 6;
    localparam int DEPTH = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          a_wr = 1'b0;
    logic [AW-1:0] a_addr = '0;
    logic [DW-1:0] a_din = '0;
    logic [DW-1:0] a_dout;
    logic          b_wr = 1'b0;
    logic [AW-1:0] b_addr = '0;
    logic [DW-1:0] b_din = '0;
    logic [DW-1:0] b_dout;
`ifdef DPRAM_COLLISION_EN
    logic          collision;
`endif

    dp_ram_sync #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .a_wr   (a_wr),
        .a_addr (a_addr),
        .a_din  (a_din),
        .a_dout (a_dout),
        .b_wr   (b_wr),
        .b_addr (b_addr),
        .b_din  (b_din),
        .b_dout (b_dout)
`ifdef DPRAM_COLLISION_EN
        ,
        .collision (collision)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            edge_no;
        string         tag;
        bit            a_known;
        logic [DW-1:0] a_val;
        bit            b_known;
        logic [DW-1:0] b_val;
        bit            coll;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: word contents plus whether each word has been written.
    logic [DW-1:0] mdl_mem   [DEPTH];
    bit            mdl_known [DEPTH];
    logic [DW-1:0] mdl_a = '0;
    logic [DW-1:0] mdl_b = '0;
    bit            mdl_a_known = 0;
    bit            mdl_b_known = 0;

    int total = 0;
    int bad   = 0;

    // Drive one cycle of operations and record what the outputs must show
    // after the coming rising edge.
    task automatic step(input string tag, input bit rst,
                        input bit awr, input logic [AW-1:0] aaddr, input logic [DW-1:0] adin,
                        input bit bwr, input logic [AW-1:0] baddr, input logic [DW-1:0] bdin);
        exp_t e;
        @(negedge clk);
        rst_n  = !rst;
        a_wr   = awr;  a_addr = aaddr; a_din = adin;
        b_wr   = bwr;  b_addr = baddr; b_din = bdin;
        e.edge_no = cyc + 1;
        e.tag     = tag;
        if (rst) begin
            mdl_a = '0; mdl_a_known = 1;
            mdl_b = '0; mdl_b_known = 1;
            e.coll = 0;
        end else begin
            // Reads see memory as it was before this edge.
            if (!awr) begin mdl_a = mdl_mem[aaddr]; mdl_a_known = mdl_known[aaddr]; end
            if (!bwr) begin mdl_b = mdl_mem[baddr]; mdl_b_known = mdl_known[baddr]; end
            e.coll = (aaddr == baddr) && (awr || bwr);
            // A is applied last so it overrides B on the same word.
            if (bwr) begin mdl_mem[baddr] = bdin; mdl_known[baddr] = 1; end
            if (awr) begin mdl_mem[aaddr] = adin; mdl_known[aaddr] = 1; end
        end
        e.a_known = mdl_a_known; e.a_val = mdl_a;
        e.b_known = mdl_b_known; e.b_val = mdl_b;
        exp_q.push_back(e);
    endtask

    // Monitor: on each falling edge, score every expectation whose edge has
    // already occurred.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0 && exp_q[0].edge_no <= cyc) begin
                e = exp_q.pop_front();
                if (e.a_known) begin
                    total++;
                    if (a_dout !== e.a_val) begin
                        bad++;
                        $display("FAIL %s a_dout: got %h want %h (edge %0d)", e.tag, a_dout, e.a_val, e.edge_no);
                    end
                end
                if (e.b_known) begin
                    total++;
                    if (b_dout !== e.b_val) begin
                        bad++;
                        $display("FAIL %s b_dout: got %h want %h (edge %0d)", e.tag, b_dout, e.b_val, e.edge_no);
                    end
                end
`ifdef DPRAM_COLLISION_EN
                total++;
                if (collision !== e.coll) begin
                    bad++;
                    $display("FAIL %s collision: got %b want %b (edge %0d)", e.tag, collision, e.coll, e.edge_no);
                end
`endif
                $display("txn edge=%0d %s a=%h b=%h", e.edge_no, e.tag, a_dout, b_dout);
            end
        end
    end

    initial begin
        logic [AW-1:0] aa, ba;
        int            wait_cnt;
        for (int i = 0; i < DEPTH; i++) begin
            mdl_mem[i]   = '0;
            mdl_known[i] = 0;
        end

        // Reset held for two cycles.
        step("reset0", 1, 0, 0, 0, 0, 0, 0);
        step("reset1", 1, 0, 0, 0, 0, 0, 0);

        // Port A write then read back on both ports.
        step("a_wr5",   0, 1, 5, 8'h3C, 0, 6, 0);
        step("a_rd5",   0, 0, 5, 0,     0, 6, 0);
        step("b_rd5",   0, 1, 6, 8'h77, 0, 5, 0);

        // Concurrent independent writes, then cross reads.
        step("wr_pair", 0, 1, 6'h10, 8'hAA, 1, 6'h20, 8'h55);
        step("rd_pair", 0, 0, 6'h20, 0,     0, 6'h10, 0);

        // Read/write collision: B reads old data, then new.
        step("set7",    0, 1, 7, 8'h11, 0, 5, 0);
        step("rw_coll", 0, 1, 7, 8'h22, 0, 7, 0);
        step("rd7",     0, 0, 6'h10, 0, 0, 7, 0);

        // Write/write collision: A wins.
        step("ww_coll", 0, 1, 9, 8'hF0, 1, 9, 8'h0F);
        step("rd9",     0, 0, 9, 0,     0, 9, 0);

        // Boundaries, reset pulse, retention.
        step("wr_0_63", 0, 1, 0, 8'h01, 1, 63, 8'hFE);
        step("rd_0_63", 0, 0, 0, 0,     0, 63, 0);
        step("rst_mid", 1, 1, 0, 8'hEE, 1, 63, 8'hEE);
        step("rd_keep", 0, 0, 0, 0,     0, 63, 0);
        step("rd_swap", 0, 0, 63, 0,    0, 0, 0);

        // Fill remaining words so random reads are fully checkable.
        for (int i = 0; i < DEPTH / 2; i++) begin
            if (!mdl_known[i] || !mdl_known[i + 32])
                step("fill", 0, 1, AW'(i), DW'($urandom), 1, AW'(i + 32), DW'($urandom));
        end

        // Random traffic; half the time addresses are squeezed into a small
        // window so same-address cases occur often.
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 1) == 1) begin
                aa = AW'($urandom_range(0, 3));
                ba = AW'($urandom_range(0, 3));
            end else begin
                aa = AW'($urandom);
                ba = AW'($urandom);
            end
            step("rand", ($urandom_range(0, 49) == 0),
                 ($urandom_range(0, 1) == 1), aa, DW'($urandom),
                 ($urandom_range(0, 1) == 1), ba, DW'($urandom));
        end
        step("idle", 0, 0, 1, 0, 0, 2, 0);

        // Drain the scoreboard within a bounded number of cycles.
        wait_cnt = 0;
        while (exp_q.size() > 0 && wait_cnt < 10) begin
            @(negedge clk);
            wait_cnt++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dp_ram_sync.md
Name: dp_ram_sync

Overview:
- Synchronous true dual-port RAM with two independent read/write ports, A and B, sharing one storage array.
- Both ports run on a single common clock.
- Used as a scratch/buffer memory; each port performs one read or one write per clock.
- Registered read outputs, one-cycle read latency.

Parameters:
- DATA_WIDTH, 8, width of each memory word and of the din/dout buses.
- ADDR_WIDTH, 6, address width. Depth = 2**ADDR_WIDTH (64 words by default).

Ports:
- clk  input  1  common clock for both ports; all activity on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- a_wr  input  1  port A operation select: 1 = write, 0 = read.
- a_addr  input  ADDR_WIDTH  port A word address.
- a_din  input  DATA_WIDTH  port A write data.
- a_dout  output  DATA_WIDTH  port A registered read data.
- b_wr  input  1  port B operation select: 1 = write, 0 = read.
- b_addr  input  ADDR_WIDTH  port B word address.
- b_din  input  DATA_WIDTH  port B write data.
- b_dout  output  DATA_WIDTH  port B registered read data.
- collision  output  1  present only with DPRAM_COLLISION_EN (see below).

Behaviour:
- Reset, when rst_n = 0 at a rising edge:
  - a_dout and b_dout are set to 0.
  - Writes on both ports are ignored.
  - Memory contents are not cleared; contents are undefined after power-up.
- Write, when x_wr = 1 at a rising edge: mem[x_addr] <= x_din. x_dout holds its previous value (no write-through).
- Read, when x_wr = 0 at a rising edge: x_dout <= mem[x_addr]. Data is visible after that edge, one-cycle latency.
- x_dout is stable between reads. It changes only on a read edge or on reset.
- Same-cycle read on one port and write on the other to the same address: read-before-write. The reading port returns the old contents, and the new data is stored.
- Both ports write the same address in the same cycle: port A wins, so mem = a_din.
- Both ports read the same address: both return the same data.
- Accesses to different addresses are fully independent; no ordering between ports.
- Full address range 0 .. 2**ADDR_WIDTH-1 is valid. No wrap logic is needed; addresses are exactly ADDR_WIDTH bits.
- Reset asserted mid-sequence: the output registers clear at that edge. Data written before reset is retained and readable after rst_n returns to 1.
- No handshake and no back-pressure; every cycle accepts a new operation on each port.

Optional Feature:
- Macro: DPRAM_COLLISION_EN.
- Defined:
  - Adds the output port collision, a 1-bit register, reset to 0.
  - collision is set to 1 for exactly the cycle after any edge where a_addr == b_addr and (a_wr | b_wr) = 1, with rst_n = 1. Otherwise it is 0.
  - Memory behaviour is unchanged; port A priority still applies.
- Not defined: the port and its logic are absent. Array behaviour is identical.

Test Plan:
- Reset: hold rst_n = 0 for 2 cycles with a_wr = b_wr = 0 -> a_dout = 0, b_dout = 0. With DPRAM_COLLISION_EN, collision = 0.
- Port A write/read: write addr 5 = 0x3C via A; next cycle read addr 5 via A -> a_dout = 0x3C one cycle after the read edge. Read addr 5 via B -> b_dout = 0x3C.
- Concurrent independent ops: A writes addr 0x10 = 0xAA while B writes addr 0x20 = 0x55 in the same cycle; then A reads 0x20 and B reads 0x10 -> a_dout = 0x55, b_dout = 0xAA.
- Read/write collision: mem[7] = 0x11. In one cycle A writes addr 7 = 0x22 and B reads addr 7 -> b_dout = 0x11. Next cycle B reads addr 7 -> b_dout = 0x22. With the macro, collision = 1 for one cycle.
- Write/write collision: A writes addr 9 = 0xF0 and B writes addr 9 = 0x0F in the same cycle; then read via both ports -> a_dout = b_dout = 0xF0.
- Boundaries and reset retention: write addr 0 = 0x01 and addr 63 = 0xFE; pulse rst_n low for 1 cycle; then read both -> 0x01 and 0xFE. Outputs read 0 during reset.
